fir_ma_channel_scheduler: RTL and testbench
===========================================

Name: fir_ma_channel_scheduler

Overview:
Time-shares one 8-tap moving-average datapath across NUM_CH independent sample streams. Each requester offers 16-bit signed samples on a valid/ready handshake. A round-robin arbiter grants one channel at a time. Per-channel history and running sums are held internally, and each result is returned tagged with its channel index. It sits between multi-channel sample sources (ADC front-ends, test ROM players) and downstream consumers, replacing NUM_CH separate filter instances.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
TAPS_LOG2, 3, log2 of tap count; 3 gives the 8-tap average
DATA_W, 16, signed sample width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  NUM_CH  per-channel sample valid
in_data  input  NUM_CH*DATA_W  per-channel signed samples; channel k at [k*DATA_W +: DATA_W]
in_ready  output  NUM_CH  one-hot acceptance; at most one bit high
clear  input  1  synchronous request to zero all channel histories and sums
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_ch  output  $clog2(NUM_CH)  channel index of result
out_data  output  DATA_W  signed moving-average result
busy  output  1  high in any state other than S_IDLE

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: in_ready=0, out_valid=0, out_ch=0, out_data=0, busy=0.
  - State: all histories, running sums, write pointers and the rr pointer cleared; FSM to S_IDLE.
  - Reset mid-operation aborts the transaction; no partial result is emitted.
- FSM states: S_IDLE, S_LOAD, S_CALC, S_OUT.
- S_IDLE:
  - If clear=1: zero all state for one cycle, grant nothing, stay in S_IDLE. clear has priority over grants.
  - Else if any in_valid: the round-robin winner g (search starts at rr_ptr) gets in_ready[g]=1 combinationally in this cycle. Sample and g are registered; go to S_LOAD.
- S_LOAD: read oldest=hist[g][wptr[g]] and sum[g] into registers; go to S_CALC.
- S_CALC:
  - new_sum = sum[g] - oldest + sample, with sum width DATA_W+TAPS_LOG2 signed; this never overflows.
  - Write hist[g][wptr[g]]=sample; wptr[g] increments modulo 2^TAPS_LOG2 (wraps 7->0).
  - out_data <= new_sum >>> TAPS_LOG2 (arithmetic shift, truncation toward -inf); out_ch <= g; out_valid <= 1; go to S_OUT.
- S_OUT:
  - Hold out_valid, out_ch and out_data stable until out_ready=1.
  - On out_valid & out_ready: out_valid <= 0, rr_ptr <= (g+1) mod NUM_CH, go to S_IDLE.
- Latency: sample accepted in cycle t gives out_valid=1 in cycle t+3. Minimum issue interval is 4 cycles with out_ready held high.
- in_ready is 0 in every state except S_IDLE. A requester holds in_valid and in_data until it sees in_ready.
- clear outside S_IDLE is ignored. Software must hold clear until busy=0.
- A channel never granted keeps its history untouched. Channels are fully independent.

Decomposition:
- Package fir_ma_pkg:
  - state_e enum (S_IDLE, S_LOAD, S_CALC, S_OUT)
  - DATA_W and TAPS_LOG2 defaults
  - sample_t (logic signed [DATA_W-1:0])
  - sum_t (logic signed [DATA_W+TAPS_LOG2-1:0])
- One sub-module, fir_rr_arbiter: NUM_CH request vector plus rr_ptr in, one-hot grant plus index out; purely combinational.
- History storage is a register array inside the top module.

Test Plan:
- Step on ch0: 0x7FFF held for 10 samples, out_ready=1 -> out_data 0x0FFF, 0x1FFF, 0x2FFF, ..., 0x7FFF at sample 8, then 0x7FFF steady; out_ch=0 throughout; out_valid exactly 3 cycles after each in_ready.
- Impulse on ch1: one 0x7FFF, then zeros -> 8 results of 0x0FFF, then 0x0000; ch0/ch2/ch3 sums unaffected (verify with a later ch0 sample of 0x0008 -> 0x0001).
- Negative rounding on ch2: single 0xFFF8 (-8) -> 0xFFFF (-1), then 7 more 0xFFFF, then 0x0000. A single 0xFFFF -> 0xFFFF for 8 outputs, then 0x0000.
- Round-robin: all four in_valid held high -> grant order 0,1,2,3,0,1; no channel granted twice before the others; in_ready is one-hot.
- Backpressure: out_ready=0 for 5 cycles in S_OUT -> out_valid/out_ch/out_data stable; in_ready=0 on all channels; no new accept until handshake completes.
- clear and reset: pulse clear in S_IDLE with in_valid=1 -> no grant that cycle, next result equals sample>>>3. Assert reset_n=0 during S_CALC -> out_valid=0 immediately; post-reset step starts from 0x0FFF.

Source files
------------

// File: rtl/fir_ma_channel_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fir_ma_pkg
//  Brief   : Shared types and default widths for the time-shared 8-tap
//            moving-average channel scheduler.
//  Rev     : 1.0  initial release
// ============================================================================
package fir_ma_pkg;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_TAPS_LOG2 = 3;

    // Sequencer states: accept, fetch history, compute/writeback, present result
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    typedef logic signed [DEF_DATA_W-1:0]               sample_t;
    typedef logic signed [DEF_DATA_W+DEF_TAPS_LOG2-1:0] sum_t;

endpackage : fir_ma_pkg
`default_nettype wire

// File: rtl/fir_ma_channel_scheduler_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : fir_rr_arbiter
//  Brief   : Combinational round-robin arbiter. The search for a requester
//            starts at rr_ptr and wraps; the first hit wins.
//  Rev     : 1.0  initial release
// ============================================================================
module fir_rr_arbiter
    import fir_ma_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_any
);

    // Scan channels in rotating priority order starting at rr_ptr
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            cand = int'(rr_ptr) + off;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_idx = cand[IDX_W-1:0];
            if (!grant_any && req[cand_idx]) begin
                grant_any       = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule : fir_rr_arbiter
`default_nettype wire

// File: rtl/fir_ma_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : fir_ma_channel_scheduler
//  Brief   : One moving-average datapath time-shared across NUM_CH sample
//            streams. Per-channel history, running sum and write pointer are
//            kept locally; each result is tagged with its channel index.
//  Rev     : 1.0  initial release
// ============================================================================
module fir_ma_channel_scheduler
    import fir_ma_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int TAPS_LOG2 = DEF_TAPS_LOG2,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    output logic [DATA_W-1:0]          out_data,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int DEPTH = 1 << TAPS_LOG2;
    localparam int SUM_W = DATA_W + TAPS_LOG2;

    // Per-channel state
    logic signed [DATA_W-1:0]  hist   [NUM_CH][DEPTH];
    logic signed [SUM_W-1:0]   sums   [NUM_CH];
    logic [TAPS_LOG2-1:0]      wptr   [NUM_CH];

    // Transaction registers
    logic [IDX_W-1:0]          rr_ptr;
    logic [IDX_W-1:0]          cur_ch;
    logic signed [DATA_W-1:0]  sample_q;
    logic signed [DATA_W-1:0]  oldest_q;
    logic signed [SUM_W-1:0]   sum_q;
    logic signed [SUM_W-1:0]   new_sum;

    state_e                    state;
    state_e                    state_nxt;
    logic                      accept;

    logic [NUM_CH-1:0]         grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_any;
    logic signed [DATA_W-1:0]  ch_data [NUM_CH];

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_unpack
            assign ch_data[k] = in_data[k*DATA_W +: DATA_W];
        end
    endgenerate

    fir_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req       (in_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign busy = (state != S_IDLE);

    // Running-sum update: drop the oldest tap, add the new sample
    always_comb begin
        new_sum = sum_q
                - $signed({{TAPS_LOG2{oldest_q[DATA_W-1]}}, oldest_q})
                + $signed({{TAPS_LOG2{sample_q[DATA_W-1]}}, sample_q});
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; clear outranks any grant
    always_comb begin
        state_nxt = state;
        in_ready  = '0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!clear && grant_any) begin
                    in_ready  = grant;
                    accept    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD:  state_nxt = S_CALC;
            S_CALC:  state_nxt = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Channel history, running sums and write pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sums[c] <= '0;
                wptr[c] <= '0;
                for (int t = 0; t < DEPTH; t++) begin
                    hist[c][t] <= '0;
                end
            end
        end else if (state == S_IDLE && clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sums[c] <= '0;
                wptr[c] <= '0;
                for (int t = 0; t < DEPTH; t++) begin
                    hist[c][t] <= '0;
                end
            end
        end else if (state == S_CALC) begin
            hist[cur_ch][wptr[cur_ch]] <= sample_q;
            sums[cur_ch]               <= new_sum;
            wptr[cur_ch]               <= wptr[cur_ch] + TAPS_LOG2'(1);
        end
    end

    // Transaction capture, result register and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            cur_ch    <= '0;
            sample_q  <= '0;
            oldest_q  <= '0;
            sum_q     <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sample_q <= ch_data[grant_idx];
                        cur_ch   <= grant_idx;
                    end
                end
                S_LOAD: begin
                    oldest_q <= hist[cur_ch][wptr[cur_ch]];
                    sum_q    <= sums[cur_ch];
                end
                S_CALC: begin
                    // Upper DATA_W bits of the sum are the arithmetic shift by TAPS_LOG2
                    out_data  <= new_sum[SUM_W-1:TAPS_LOG2];
                    out_ch    <= cur_ch;
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rr_ptr    <= (cur_ch == IDX_W'(NUM_CH - 1)) ? '0
                                                                    : cur_ch + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : fir_ma_channel_scheduler
`default_nettype wire

// File: tb/tb_fir_ma_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fir_ma_channel_scheduler
//  Brief   : Directed self-checking bench for the channel scheduler.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_fir_ma_channel_scheduler;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 16;
    localparam int TAPS_LOG2 = 3;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH*DATA_W-1:0]  in_data;
    logic [NUM_CH-1:0]         in_ready;
    logic                      clear;
    logic                      out_valid;
    logic                      out_ready;
    logic [1:0]                out_ch;
    logic [DATA_W-1:0]         out_data;
    logic                      busy;

    int checks = 0;
    int errors = 0;

    int          rr_order [6] = '{0, 1, 2, 3, 0, 1};
    logic [15:0] rr_exp   [6] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0200};

    always #5 clk = ~clk;

    fir_ma_channel_scheduler #(
        .NUM_CH    (NUM_CH),
        .TAPS_LOG2 (TAPS_LOG2),
        .DATA_W    (DATA_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the one-hot grant of channel ch
    task automatic wait_grant(input int ch, input string tag);
        int n;
        n = 0;
        while (in_ready !== (NUM_CH'(1) << ch) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, ":grant"}, 32'(in_ready), 32'(NUM_CH'(1) << ch));
    endtask

    // One sample through the pipe with out_ready high; checks latency and result
    task automatic xfer(input int ch, input logic [15:0] d, input logic [15:0] exp, input string tag);
        @(negedge clk);
        clear = 1'b0;
        in_valid[ch] = 1'b1;
        in_data[ch*DATA_W +: DATA_W] = d;
        #1;
        wait_grant(ch, tag);
        @(negedge clk);
        in_valid[ch] = 1'b0;
        #1;
        chk({tag, ":load_ready"}, 32'(in_ready), 32'h0);
        chk({tag, ":load_busy"}, 32'(busy), 32'h1);
        @(negedge clk); #1;
        chk({tag, ":calc_valid"}, 32'(out_valid), 32'h0);
        @(negedge clk); #1;
        chk({tag, ":out_valid"}, 32'(out_valid), 32'h1);
        chk({tag, ":out_ch"}, 32'(out_ch), 32'(ch));
        chk({tag, ":out_data"}, 32'(out_data), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst:in_ready", 32'(in_ready), 32'h0);
        chk("rst:out_valid", 32'(out_valid), 32'h0);
        chk("rst:out_ch", 32'(out_ch), 32'h0);
        chk("rst:out_data", 32'(out_data), 32'h0);
        chk("rst:busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Round-robin with all channels requesting, 0x0800 each
        @(negedge clk);
        in_valid = '1;
        for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = 16'h0800;
        #1;
        for (int i = 0; i < 6; i++) begin
            wait_grant(rr_order[i], "rr");
            @(negedge clk);
            if (i == 5) in_valid = '0;
            #1;
            chk("rr:load_ready", 32'(in_ready), 32'h0);
            @(negedge clk);
            @(negedge clk); #1;
            chk("rr:out_valid", 32'(out_valid), 32'h1);
            chk("rr:out_ch", 32'(out_ch), 32'(rr_order[i]));
            chk("rr:out_data", 32'(out_data), 32'(rr_exp[i]));
            @(negedge clk); #1;
        end

        // Backpressure on ch3 result; ch0 requests meanwhile
        out_ready = 1'b0;
        in_valid[3] = 1'b1;
        #1;
        wait_grant(3, "bp");
        @(negedge clk);
        in_valid[3] = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("bp:out_valid", 32'(out_valid), 32'h1);
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp:hold_valid", 32'(out_valid), 32'h1);
            chk("bp:hold_ch", 32'(out_ch), 32'h3);
            chk("bp:hold_data", 32'(out_data), 32'h0200);
            chk("bp:hold_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp:wrap_grant", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("bp:ch0_ch", 32'(out_ch), 32'h0);
        chk("bp:ch0_data", 32'(out_data), 32'h0300);

        // Reset asserted during S_CALC aborts the transaction
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0 +: DATA_W] = 16'h7FFF;
        #1;
        wait_grant(0, "abort");
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk); #1;
        chk("abort:calc_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("abort:out_valid", 32'(out_valid), 32'h0);
        chk("abort:busy", 32'(busy), 32'h0);
        chk("abort:out_data", 32'(out_data), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("abort:no_result", 32'(out_valid), 32'h0);
        end

        // Step of 0x7FFF on ch0
        for (int k = 1; k <= 10; k++) begin
            xfer(0, 16'h7FFF, (k <= 8) ? 16'(k * 4096 - 1) : 16'h7FFF, "step");
        end

        // clear in S_IDLE with a pending request: no grant that cycle
        @(negedge clk);
        clear = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0 +: DATA_W] = 16'h0000;
        #1;
        chk("clr:no_grant", 32'(in_ready), 32'h0);
        chk("clr:busy", 32'(busy), 32'h0);
        xfer(0, 16'h0000, 16'h0000, "clr");

        // Impulse on ch1, then confirm ch0 is independent
        xfer(1, 16'h7FFF, 16'h0FFF, "imp");
        for (int i = 0; i < 7; i++) xfer(1, 16'h0000, 16'h0FFF, "imp");
        xfer(1, 16'h0000, 16'h0000, "imp_end");
        xfer(0, 16'h0008, 16'h0001, "indep");

        // Negative values round toward -inf on ch2
        xfer(2, 16'hFFF8, 16'hFFFF, "neg8");
        for (int i = 0; i < 7; i++) xfer(2, 16'h0000, 16'hFFFF, "neg8");
        xfer(2, 16'h0000, 16'h0000, "neg8_end");
        xfer(2, 16'hFFFF, 16'hFFFF, "neg1");
        for (int i = 0; i < 7; i++) xfer(2, 16'h0000, 16'hFFFF, "neg1");
        xfer(2, 16'h0000, 16'h0000, "neg1_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fir_ma_channel_scheduler
`default_nettype wire
